// File: rtl/riscv_fetch_stage_pkg.sv
// Shared constants, payload type and helpers for the instruction-fetch stage.
package riscv_fetch_stage_pkg;

  localparam int unsigned XLEN             = 32;
  localparam int unsigned FETCH_FIFO_DEPTH = 2;

  localparam logic [XLEN-1:0] FETCH_RESET_PC = 32'h0000_2000;
  localparam logic [XLEN-1:0] FETCH_NOP_INST = 32'h0000_0013;  // addi x0,x0,0

  // One buffered instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

  // Clear the byte-offset bits of a target address.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_inst_fifo.sv
// Small synchronous FIFO with flush; flush dominates push and pop.
module fetch_inst_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count != '0);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  // Storage; contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/riscv_fetch_stage.sv
// Instruction-fetch stage: PC, credit-limited imem requests, response buffer, NOP substitution.
module riscv_fetch_stage
  import riscv_fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = FETCH_RESET_PC,
  parameter int unsigned     FIFO_DEPTH = FETCH_FIFO_DEPTH,
  parameter logic [XLEN-1:0] NOP_INST   = FETCH_NOP_INST
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            f_valid,
  output logic [XLEN-1:0] f_inst,
  output logic [XLEN-1:0] f_pc
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OW = CW + 1;

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   buf_count;
  logic [XLEN-1:0] pending_pc;
  logic [OW-1:0]   occupancy;
  fetch_entry_t    head_entry;
  fetch_entry_t    push_entry;
  logic            req_fire;
  logic            resp_drop;
  logic            resp_keep;
  logic            pop;

  // Credit check: a same-cycle pop frees its slot so a 1-cycle imem sustains one instruction per cycle.
  assign pop            = f_valid && !stall;
  assign occupancy      = OW'(inflight) + OW'(buf_count) - OW'(pop);
  assign imem_req_valid = reset_n && !redirect_valid && (occupancy < OW'(FIFO_DEPTH));
  assign imem_addr      = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign resp_drop      = imem_resp_valid && (drop_cnt != '0);
  assign resp_keep      = imem_resp_valid && (drop_cnt == '0);
  assign push_entry     = {pending_pc, imem_resp_data};

  // PCs of outstanding requests, in issue order; its depth is the in-flight count.
  fetch_inst_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (XLEN)
  ) u_pc_q (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (req_fire),
    .pop     (imem_resp_valid),
    .flush   (1'b0),
    .din     (pc),
    .count   (inflight),
    .head    (pending_pc)
  );

  // Returned instructions awaiting decode; a redirect discards them.
  fetch_inst_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FETCH_ENTRY_W)
  ) u_inst_q (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (resp_keep),
    .pop     (pop),
    .flush   (redirect_valid),
    .din     (push_entry),
    .count   (buf_count),
    .head    (head_entry)
  );

  // PC advance and count of stale responses still to be discarded after a redirect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc       <= RESET_PC;
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      pc       <= word_align(redirect_pc);
      drop_cnt <= inflight + CW'(req_fire) - CW'(imem_resp_valid);
    end else begin
      if (req_fire)  pc       <= pc + XLEN'(4);
      if (resp_drop) drop_cnt <= drop_cnt - CW'(1);
    end
  end

  // Present the buffer head to decode, or a NOP when nothing is buffered.
  always_comb begin
    f_valid = (buf_count != '0);
    f_inst  = NOP_INST;
    f_pc    = '0;
    if (f_valid) begin
      f_inst = head_entry.inst;
      f_pc   = head_entry.pc;
    end
  end

  // Every response must correspond to an outstanding request.
  resp_has_request: assert property (@(posedge clk) disable iff (!reset_n)
    imem_resp_valid |-> (inflight != '0));

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// Directed bench for riscv_fetch_stage with a 1-cycle in-order imem model.
module tb_riscv_fetch_stage;

  logic        clk;
  logic        reset_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        f_valid;
  logic [31:0] f_inst;
  logic [31:0] f_pc;

  int          checks;
  int          errors;
  logic [31:0] req_q[$];
  logic [63:0] deliv_q[$];
  bit          resp_hold;

  riscv_fetch_stage dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .f_valid         (f_valid),
    .f_inst          (f_inst),
    .f_pc            (f_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // Record accepted requests and instructions consumed by decode.
  always @(posedge clk) begin
    if (reset_n && imem_req_valid && imem_req_ready) req_q.push_back(imem_addr);
    if (reset_n && f_valid && !stall) deliv_q.push_back({f_pc, f_inst});
  end

  // imem: answer each request on the following cycle unless held; forget everything in reset.
  always @(negedge clk) begin
    if (!reset_n) begin
      req_q.delete();
      imem_resp_valid = 1'b0;
    end else if (!resp_hold && req_q.size() != 0) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = inst_of(req_q.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
    end
  end

  task automatic win();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    resp_hold      = 1'b0;
    deliv_q.delete();
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    #1;
  endtask

  task automatic wait_deliv(input int n);
    int cyc;
    cyc = 0;
    while (deliv_q.size() < n && cyc < 40) begin
      win();
      cyc++;
    end
    checks++;
    if (deliv_q.size() < n) begin
      errors++;
      $display("FAIL deliv_timeout got %0d entries exp %0d", deliv_q.size(), n);
    end
  endtask

  task automatic test_reset();
    reset_n        = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    resp_hold      = 1'b0;
    #1 reset_n = 1'b0;
    #2;
    checks++;
    if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b exp 0", imem_req_valid); end
    checks++;
    if (f_valid !== 1'b0) begin errors++; $display("FAIL reset_f_valid got %b exp 0", f_valid); end
    checks++;
    if (f_inst !== 32'h0000_0013 || f_pc !== 32'h0) begin
      errors++; $display("FAIL reset_f_out got %h/%h exp 00000013/00000000", f_inst, f_pc);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin win(); #1; end
      exp_addr = 32'h2000 + 32'(4 * k);
      checks++;
      if (imem_req_valid !== 1'b1 || imem_addr !== exp_addr) begin
        errors++; $display("FAIL stream_req k=%0d got %b/%h exp 1/%h", k, imem_req_valid, imem_addr, exp_addr);
      end
      checks++;
      if (f_valid !== (k >= 2)) begin
        errors++; $display("FAIL stream_f_valid k=%0d got %b exp %b", k, f_valid, k >= 2);
      end
      exp_pc = (k >= 2) ? 32'h2000 + 32'(4 * (k - 2)) : 32'h0;
      checks++;
      if (f_pc !== exp_pc || f_inst !== ((k >= 2) ? inst_of(exp_pc) : 32'h0000_0013)) begin
        errors++; $display("FAIL stream_f_out k=%0d got %h/%h exp pc %h", k, f_pc, f_inst, exp_pc);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc;
    do_reset();
    repeat (3) win();
    stall = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin win(); #1; end
      checks++;
      if (f_valid !== 1'b1 || f_pc !== 32'h2004) begin
        errors++; $display("FAIL stall_hold k=%0d got %b/%h exp 1/00002004", k, f_valid, f_pc);
      end
      checks++;
      if (imem_req_valid !== 1'b0) begin
        errors++; $display("FAIL stall_credit k=%0d got req_valid %b exp 0", k, imem_req_valid);
      end
    end
    win();
    stall = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200C) begin
      errors++; $display("FAIL stall_resume got %b/%h exp 1/0000200c", imem_req_valid, imem_addr);
    end
    wait_deliv(6);
    for (int i = 0; i < deliv_q.size() && i < 6; i++) begin
      exp_pc = 32'h2000 + 32'(4 * i);
      checks++;
      if (deliv_q[i] !== {exp_pc, inst_of(exp_pc)}) begin
        errors++; $display("FAIL stall_order i=%0d got %h exp %h", i, deliv_q[i], {exp_pc, inst_of(exp_pc)});
      end
    end
  endtask

  task automatic test_redirect();
    logic [31:0] exp_pc;
    do_reset();
    resp_hold = 1'b1;
    win(); #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h2004) begin
      errors++; $display("FAIL redir_second_req got %b/%h exp 1/00002004", imem_req_valid, imem_addr);
    end
    win();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3001;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL redir_no_req got %b exp 0", imem_req_valid); end
    resp_hold = 1'b0;
    win();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (f_valid !== 1'b0 || imem_addr !== 32'h3000) begin
      errors++; $display("FAIL redir_next got %b/%h exp 0/00003000", f_valid, imem_addr);
    end
    win(); #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h3000 || f_valid !== 1'b0) begin
      errors++; $display("FAIL redir_target_req got %b/%h f_valid %b exp 1/00003000 f_valid 0", imem_req_valid, imem_addr, f_valid);
    end
    wait_deliv(3);
    for (int i = 0; i < deliv_q.size() && i < 3; i++) begin
      exp_pc = 32'h3000 + 32'(4 * i);
      checks++;
      if (deliv_q[i] !== {exp_pc, inst_of(exp_pc)}) begin
        errors++; $display("FAIL redir_order i=%0d got %h exp %h", i, deliv_q[i], {exp_pc, inst_of(exp_pc)});
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc;
    do_reset();
    win(); win();
    imem_req_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin win(); #1; end
      checks++;
      if (imem_req_valid !== 1'b1 || imem_addr !== 32'h2008) begin
        errors++; $display("FAIL bp_hold k=%0d got %b/%h exp 1/00002008", k, imem_req_valid, imem_addr);
      end
      if (k == 2) begin
        checks++;
        if (f_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got f_valid %b exp 0", f_valid); end
      end
    end
    win();
    imem_req_ready = 1'b1;
    #1;
    checks++;
    if (imem_addr !== 32'h2008) begin errors++; $display("FAIL bp_release got %h exp 00002008", imem_addr); end
    wait_deliv(4);
    for (int i = 0; i < deliv_q.size() && i < 4; i++) begin
      exp_pc = 32'h2000 + 32'(4 * i);
      checks++;
      if (deliv_q[i] !== {exp_pc, inst_of(exp_pc)}) begin
        errors++; $display("FAIL bp_order i=%0d got %h exp %h", i, deliv_q[i], {exp_pc, inst_of(exp_pc)});
      end
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    win(); win();
    reset_n = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || f_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_valids got %b/%b exp 0/0", imem_req_valid, f_valid);
    end
    checks++;
    if (f_inst !== 32'h0000_0013 || f_pc !== 32'h0) begin
      errors++; $display("FAIL midreset_f_out got %h/%h exp 00000013/00000000", f_inst, f_pc);
    end
    do_reset();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h2000) begin
      errors++; $display("FAIL midreset_first_req got %b/%h exp 1/00002000", imem_req_valid, imem_addr);
    end
    wait_deliv(2);
    for (int i = 0; i < deliv_q.size() && i < 2; i++) begin
      checks++;
      if (deliv_q[i][63:32] !== 32'h2000 + 32'(4 * i)) begin
        errors++; $display("FAIL midreset_order i=%0d got %h exp %h", i, deliv_q[i][63:32], 32'h2000 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL wrap_redir_req got %b exp 0", imem_req_valid); end
    win();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_first got %b/%h exp 1/fffffffc", imem_req_valid, imem_addr);
    end
    win(); #1;
    checks++;
    if (imem_addr !== 32'h0000_0000) begin errors++; $display("FAIL wrap_addr got %h exp 00000000", imem_addr); end
    wait_deliv(2);
    if (deliv_q.size() >= 2) begin
      checks++;
      if (deliv_q[0] !== {32'hFFFF_FFFC, inst_of(32'hFFFF_FFFC)} || deliv_q[1] !== {32'h0, inst_of(32'h0)}) begin
        errors++; $display("FAIL wrap_deliv got %h,%h exp pcs fffffffc,00000000", deliv_q[0], deliv_q[1]);
      end
    end
  endtask

  task automatic test_redirect_stall();
    do_reset();
    repeat (3) win();
    stall = 1'b1;
    win();
    win();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h4000;
    #1;
    checks++;
    if (f_valid !== 1'b1 || f_pc !== 32'h2004) begin
      errors++; $display("FAIL rs_before got %b/%h exp 1/00002004", f_valid, f_pc);
    end
    win();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (f_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h4000) begin
      errors++; $display("FAIL rs_flush got f_valid %b req %b/%h exp 0 1/00004000", f_valid, imem_req_valid, imem_addr);
    end
    win();
    stall = 1'b0;
    wait_deliv(2);
    if (deliv_q.size() >= 2) begin
      checks++;
      if (deliv_q[1] !== {32'h4000, inst_of(32'h4000)}) begin
        errors++; $display("FAIL rs_target got %h exp %h", deliv_q[1], {32'h4000, inst_of(32'h4000)});
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_backpressure();
    test_reset_midstream();
    test_wrap();
    test_redirect_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
